// File: rtl/tdc_multi_merge.sv
// tdc_multi_merge
// Multi-channel TDC merge stage. Each channel measures a pulse width in
// coarse iClk ticks, waits SETTLE cycles for the fine decoders and captures
// the start/stop fine codes. A round-robin arbiter moves completed stamps
// into a shared first-word-fall-through FIFO.
//
// Ports:
//   iClk, rst           clock, synchronous active-high reset
//   iEnable             arm idle channels for new measurements
//   iRise, iFall        per-channel 1-cycle edge strobes
//   iFineStart/Stop     packed decoded fine codes, channel c at [c*FINE_W +: FINE_W]
//   oData/oValid/iReady FIFO head {sat, ch, coarse, fineStart, fineStop}, valid/ready
//   oCount              FIFO occupancy
//   oOverflow           sticky: a rise has been dropped
//   oDropCount          dropped rises, saturating at 255
//   oBusy               some channel is not idle
//
// Channel states:
//   state     | meaning
//   ST_IDLE   | waiting for an enabled rise
//   ST_MEAS   | counting coarse ticks until fall
//   ST_SETTLE | waiting for fine decoders to settle
//   ST_PEND   | stamp complete, requesting the arbiter
module tdc_multi_merge #(
    parameter  int NUM_CH     = 4,
    parameter  int FINE_W     = 7,
    parameter  int COARSE_W   = 10,
    parameter  int SETTLE     = 1,
    parameter  int FIFO_DEPTH = 16,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int OUT_W      = 1 + CH_W + COARSE_W + 2*FINE_W,
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                     iClk,
    input  logic                     rst,
    input  logic                     iEnable,
    input  logic [NUM_CH-1:0]        iRise,
    input  logic [NUM_CH-1:0]        iFall,
    input  logic [NUM_CH*FINE_W-1:0] iFineStart,
    input  logic [NUM_CH*FINE_W-1:0] iFineStop,
    output logic [OUT_W-1:0]         oData,
    output logic                     oValid,
    input  logic                     iReady,
    output logic [CNT_W-1:0]         oCount,
    output logic                     oOverflow,
    output logic [7:0]               oDropCount,
    output logic                     oBusy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int SET_W = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_MEAS, ST_SETTLE, ST_PEND} chState_t;

    chState_t            state        [NUM_CH];
    chState_t            stateNxt     [NUM_CH];
    logic [COARSE_W-1:0] measCnt      [NUM_CH];
    logic [COARSE_W-1:0] measCntNxt   [NUM_CH];
    logic [COARSE_W-1:0] coarse       [NUM_CH];
    logic [COARSE_W-1:0] coarseNxt    [NUM_CH];
    logic                sat          [NUM_CH];
    logic                satNxt       [NUM_CH];
    logic [SET_W-1:0]    settleCnt    [NUM_CH];
    logic [SET_W-1:0]    settleCntNxt [NUM_CH];
    logic [FINE_W-1:0]   fineStart    [NUM_CH];
    logic [FINE_W-1:0]   fineStartNxt [NUM_CH];
    logic [FINE_W-1:0]   fineStop     [NUM_CH];
    logic [FINE_W-1:0]   fineStopNxt  [NUM_CH];

    logic [NUM_CH-1:0]   drop;
    logic [NUM_CH-1:0]   pendReq;
    logic [NUM_CH-1:0]   grantVec;
    logic                grantValid;
    logic [CH_W-1:0]     grantCh;
    logic [CH_W-1:0]     rrPtr;

    logic [OUT_W-1:0]    mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wrPtr, rdPtr;
    logic                fifoFull, push, pop;
    logic [8:0]          dropSum, dropTotal;

    // Channel index 'off' positions after 'base', wrapping at NUM_CH.
    function automatic logic [CH_W-1:0] rrIdx(input logic [CH_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_CH) sum -= NUM_CH;
        return CH_W'(sum);
    endfunction

    always_ff @(posedge iClk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (rst) begin
                state[c]     <= ST_IDLE;
                measCnt[c]   <= '0;
                coarse[c]    <= '0;
                sat[c]       <= 1'b0;
                settleCnt[c] <= '0;
                fineStart[c] <= '0;
                fineStop[c]  <= '0;
            end else begin
                state[c]     <= stateNxt[c];
                measCnt[c]   <= measCntNxt[c];
                coarse[c]    <= coarseNxt[c];
                sat[c]       <= satNxt[c];
                settleCnt[c] <= settleCntNxt[c];
                fineStart[c] <= fineStartNxt[c];
                fineStop[c]  <= fineStopNxt[c];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            stateNxt[c]     = state[c];
            measCntNxt[c]   = measCnt[c];
            coarseNxt[c]    = coarse[c];
            satNxt[c]       = sat[c];
            settleCntNxt[c] = settleCnt[c];
            fineStartNxt[c] = fineStart[c];
            fineStopNxt[c]  = fineStop[c];
            drop[c]         = 1'b0;
            case (state[c])
                ST_IDLE: begin
                    if (iRise[c] && iEnable) begin
                        measCntNxt[c] = '0;
                        if (iFall[c]) begin
                            coarseNxt[c]    = '0;
                            satNxt[c]       = 1'b0;
                            settleCntNxt[c] = SET_W'(SETTLE);
                            stateNxt[c]     = ST_SETTLE;
                        end else begin
                            stateNxt[c] = ST_MEAS;
                        end
                    end
                end
                ST_MEAS: begin
                    drop[c] = iRise[c];
                    // measCnt lags the true width by one; all-ones means the
                    // width is already beyond the coarse range.
                    if (iFall[c]) begin
                        if (measCnt[c] == '1) begin
                            coarseNxt[c] = '1;
                            satNxt[c]    = 1'b1;
                        end else begin
                            coarseNxt[c] = measCnt[c] + COARSE_W'(1);
                            satNxt[c]    = 1'b0;
                        end
                        settleCntNxt[c] = SET_W'(SETTLE);
                        stateNxt[c]     = ST_SETTLE;
                    end else if (measCnt[c] != '1) begin
                        measCntNxt[c] = measCnt[c] + COARSE_W'(1);
                    end
                end
                ST_SETTLE: begin
                    drop[c] = iRise[c];
                    if (settleCnt[c] == SET_W'(1)) begin
                        fineStartNxt[c] = iFineStart[c*FINE_W +: FINE_W];
                        fineStopNxt[c]  = iFineStop[c*FINE_W +: FINE_W];
                        stateNxt[c]     = ST_PEND;
                    end else begin
                        settleCntNxt[c] = settleCnt[c] - SET_W'(1);
                    end
                end
                ST_PEND: begin
                    drop[c] = iRise[c];
                    if (grantVec[c]) stateNxt[c] = ST_IDLE;
                end
                default: stateNxt[c] = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        oBusy = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            pendReq[c] = (state[c] == ST_PEND);
            oBusy      = oBusy | (state[c] != ST_IDLE);
        end
    end

    always_comb begin
        grantValid = 1'b0;
        grantCh    = '0;
        grantVec   = '0;
        if (!fifoFull) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!grantValid && pendReq[rrIdx(rrPtr, i)]) begin
                    grantValid = 1'b1;
                    grantCh    = rrIdx(rrPtr, i);
                end
            end
        end
        if (grantValid) grantVec[grantCh] = 1'b1;
    end

    always_ff @(posedge iClk) begin
        if (rst)             rrPtr <= '0;
        else if (grantValid) rrPtr <= rrIdx(grantCh, 1);
    end

    assign fifoFull = (oCount == CNT_W'(FIFO_DEPTH));
    assign oValid   = (oCount != '0);
    assign push     = grantValid;
    assign pop      = oValid && iReady;
    assign oData    = oValid ? mem[rdPtr] : '0;

    always_ff @(posedge iClk) begin
        if (push) mem[wrPtr] <= {sat[grantCh], grantCh, coarse[grantCh],
                                 fineStart[grantCh], fineStop[grantCh]};
    end

    always_ff @(posedge iClk) begin
        if (rst) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            oCount <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PTR_W'(1);
            if (pop)  rdPtr <= rdPtr + PTR_W'(1);
            case ({push, pop})
                2'b10:   oCount <= oCount + CNT_W'(1);
                2'b01:   oCount <= oCount - CNT_W'(1);
                default: oCount <= oCount;
            endcase
        end
    end

    always_comb begin
        dropSum = '0;
        for (int c = 0; c < NUM_CH; c++) dropSum = dropSum + 9'(drop[c]);
        dropTotal = {1'b0, oDropCount} + dropSum;
    end

    always_ff @(posedge iClk) begin
        if (rst) begin
            oOverflow  <= 1'b0;
            oDropCount <= '0;
        end else begin
            if (|drop) oOverflow <= 1'b1;
            oDropCount <= (dropTotal > 9'd255) ? 8'hFF : dropTotal[7:0];
        end
    end
endmodule

// File: doc/tdc_multi_merge.md
Name: tdc_multi_merge

Overview:
Parametrised multi-channel successor to the single-channel TDC merge stage. Per channel, it:
- measures pulse width in coarse clock ticks between rise and fall strobes;
- waits a programmable settle time for the fine decoders;
- captures the decoded start/stop fine codes.

A round-robin arbiter funnels completed stamps into a shared first-word-fall-through FIFO with a valid/ready output and overflow/drop accounting. The block sits between the per-channel edge detectors and thermometer decoders and the readout interface.

Parameters:
- NUM_CH, 4, number of TDC channels (1..16).
- FINE_W, 7, width of each decoded fine code.
- COARSE_W, 10, width of the coarse pulse-width count.
- SETTLE, 1, cycles from fall to fine-code capture (≥1).
- FIFO_DEPTH, 16, output FIFO entries (power of 2, ≥2).
- Derived (localparam):
  - CH_W = max(1, clog2(NUM_CH)).
  - OUT_W = 1 + CH_W + COARSE_W + 2*FINE_W.
  - CNT_W = clog2(FIFO_DEPTH) + 1.

Ports:
- iClk, input, 1: clock.
- rst, input, 1: reset, synchronous, active-high.
- iEnable, input, 1: arm channels for new measurements.
- iRise, input, NUM_CH: per-channel rise strobe, 1-cycle pulse, iClk domain.
- iFall, input, NUM_CH: per-channel fall strobe, 1-cycle pulse.
- iFineStart, input, NUM_CH*FINE_W: decoded start codes; channel c occupies [c*FINE_W +: FINE_W].
- iFineStop, input, NUM_CH*FINE_W: decoded stop codes, same packing.
- oData, output, OUT_W: FIFO head, {sat, ch, coarse, fineStart, fineStop}, MSB first.
- oValid, output, 1: FIFO not empty.
- iReady, input, 1: consumer accepts oData.
- oCount, output, CNT_W: FIFO occupancy.
- oOverflow, output, 1: sticky; at least one rise has been dropped.
- oDropCount, output, 8: dropped-rise counter, saturating at 255.
- oBusy, output, 1: OR over channels not in IDLE.

Behaviour:
- Reset (rst=1 at an edge): all channel FSMs go to IDLE. FIFO is emptied. oValid=0, oData=0, oCount=0, oOverflow=0, oDropCount=0, oBusy=0, RR pointer=0. Reset overrides all in-flight activity; partial measurements are discarded.
- Per-channel FSM, states IDLE, MEAS, SETTLE, PEND:
  - IDLE: on iRise[c] & iEnable, clear coarse counter to 0 and go to MEAS. If iFall[c] is also high in the same cycle, the zero-width event goes straight to SETTLE with coarse=0, sat=0.
  - IDLE: iFall alone is ignored. A rise with iEnable=0 is ignored and is not counted as a drop.
  - MEAS: counter increments each cycle. On iFall[c] at edge k, for a rise at edge r, capture coarse = k−r. If k−r > 2^COARSE_W−1, capture coarse = all ones and sat=1. Then go to SETTLE with settle counter = SETTLE.
  - SETTLE: decrement the settle counter. At edge k+SETTLE, latch iFineStart/iFineStop slices for channel c and go to PEND.
  - PEND: request the arbiter. On grant, go to IDLE.
- A rise in MEAS, SETTLE or PEND is dropped. oDropCount increments (saturating) and oOverflow sets. Simultaneous drops on several channels in one cycle each count, saturating.
- Dropping iEnable mid-measurement does not abort; in-flight channels complete.
- Arbiter:
  - At most one grant per cycle.
  - Round-robin starting at the channel after the last granted one.
  - Grants only if the FIFO is not full.
  - The granted word is written at the same edge.
  - While the FIFO is full, PEND channels hold (backpressure).
- FIFO:
  - Pop on oValid & iReady.
  - Push and pop in the same cycle is allowed when not full or empty; oCount is unchanged.
  - When full, no push occurs even if a pop happens that cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency with SETTLE=S, no contention, FIFO not full: fall at edge k → fine capture at k+S → FIFO write at k+S+1 → oValid=1 after edge k+S+1.

Test Plan:
1. Single pulse, ch0: rise at edge 10, fall at edge 15, fineStart=0x12, fineStop=0x05, S=1, iReady=1 → oValid after edge 17, oData={0, 0, 5, 0x12, 0x05}, then oCount returns to 0.
2. Simultaneous falls on ch0..ch3 in the same cycle → four words in order ch0, ch1, ch2, ch3 on consecutive cycles. A second burst after the last grant to ch3 is ordered starting from ch0 again.
3. Saturation, COARSE_W=4: pulse of 20 cycles → coarse=0xF, sat=1. Zero-width (rise and fall in the same cycle) → coarse=0, sat=0.
4. Backpressure: iReady=0, 17 pulses on ch1, FIFO_DEPTH=16:
   - oCount=16; ch1 holds in PEND.
   - A further rise on ch1 → oDropCount=1, oOverflow=1.
   - Raise iReady → 17 words drain in order.
5. Rise on ch2 during its SETTLE → dropped, counted. The original measurement is still delivered unchanged.
6. Reset asserted while ch0 is in MEAS with 3 FIFO entries → all outputs 0 the next cycle. The subsequent fall on ch0 produces nothing.
